// File: rtl/keypad_scan_4x4_if.sv
// keypad_scan_4x4_if
//   Bundles the keypad matrix lines and the decoded key outputs of keypad_scan_4x4.
//   master : the scanner (drives KEY_ROW and the key outputs, senses KEY_COL)
//   slave  : the keypad/consumer side (drives KEY_COL, observes everything else)
//   KEY_ROW   [3:0] row drive, active-low, one-hot-low
//   KEY_COL   [3:0] column sense, active-low
//   key_code  [3:0] last accepted key, 4*row + col
//   key_valid       one-cycle pulse on an accepted press
//   key_held        accepted key considered down
//   press_cnt [7:0] accepted press counter, wraps
interface keypad_scan_4x4_if;
    logic [3:0] KEY_ROW;
    logic [3:0] KEY_COL;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] press_cnt;

    modport master (
        output KEY_ROW, key_code, key_valid, key_held, press_cnt,
        input  KEY_COL
    );

    modport slave (
        input  KEY_ROW, key_code, key_valid, key_held, press_cnt,
        output KEY_COL
    );
endinterface

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4
//   Scans a 4x4 matrix keypad: drives one row low at a time for SCAN_DIV clocks,
//   samples the synchronized columns at the end of each dwell, classifies every
//   full 4-row frame as none / single key / multiple keys, and debounces across
//   DEBOUNCE identical frames before reporting a press or a release.
//   Ports:
//     clk  system clock
//     rst  asynchronous reset, active-low
//     kp   keypad_scan_4x4_if.master (KEY_ROW, KEY_COL, key_code, key_valid,
//          key_held, press_cnt)
module keypad_scan_4x4 #(
    parameter int unsigned SCAN_DIV = 200,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_scan_4x4_if.master     kp
);

    localparam int unsigned    CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]     DEB_N      = 3'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;
    typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_t;

    logic [3:0]    col_s1, col_s2;
    logic [1:0]    row_idx;
    logic [CW-1:0] dwell;
    logic [3:0]    key_row;
    logic [1:0]    acc_hits;     // 0, 1, or 2 meaning "two or more"
    logic [3:0]    acc_key;
    logic          fr_valid;
    frame_t        fr_kind;
    logic [3:0]    fr_key;

    state_t        state, state_nxt;
    logic [2:0]    deb, deb_nxt;
    logic [3:0]    cand, cand_nxt;
    logic          accept;
    logic [3:0]    key_code_r;
    logic          key_valid_r;
    logic          key_held_r;
    logic [7:0]    press_cnt_r;

    logic [2:0]    row_hits;
    logic [1:0]    col_idx;
    logic [1:0]    hits_base;
    logic [2:0]    hits_total;
    logic [1:0]    hits_sum;
    logic [3:0]    key_sum;
    logic [1:0]    row_next;

    assign kp.KEY_ROW   = key_row;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = key_held_r;
    assign kp.press_cnt = press_cnt_r;

    assign row_next = row_idx + 2'd1;

    // Fold the current row's lows into the running frame tally; row 0 starts a fresh frame.
    always_comb begin
        row_hits = '0;
        col_idx  = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            if (!col_s2[c]) begin
                row_hits = row_hits + 3'd1;
                col_idx  = 2'(c);
            end
        end
        hits_base  = (row_idx == 2'd0) ? 2'd0 : acc_hits;
        hits_total = 3'(hits_base) + row_hits;
        hits_sum   = (hits_total >= 3'd2) ? 2'd2 : hits_total[1:0];
        key_sum    = (row_hits == 3'd1) ? {row_idx, col_idx} : acc_key;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1   <= '1;
            col_s2   <= '1;
            row_idx  <= '0;
            dwell    <= '0;
            key_row  <= 4'b1110;
            acc_hits <= '0;
            acc_key  <= '0;
            fr_valid <= 1'b0;
            fr_kind  <= FR_NONE;
            fr_key   <= '0;
        end else begin
            col_s1   <= kp.KEY_COL;
            col_s2   <= col_s1;
            fr_valid <= 1'b0;
            if (dwell == DWELL_LAST) begin
                dwell    <= '0;
                row_idx  <= row_next;
                key_row  <= ~(4'b0001 << row_next);
                acc_hits <= hits_sum;
                acc_key  <= key_sum;
                if (row_idx == 2'd3) begin
                    fr_valid <= 1'b1;
                    fr_key   <= key_sum;
                    case (hits_sum)
                        2'd0:    fr_kind <= FR_NONE;
                        2'd1:    fr_kind <= FR_SINGLE;
                        default: fr_kind <= FR_MULTI;
                    endcase
                end
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    // Acceptance is folded into the transition to HELD rather than being a state,
    // so the pulse is issued in the same cycle the FSM acts on the frame.
    always_comb begin
        state_nxt = state;
        deb_nxt   = deb;
        cand_nxt  = cand;
        accept    = 1'b0;
        if (fr_valid) begin
            case (state)
                IDLE: begin
                    if (fr_kind == FR_SINGLE) begin
                        cand_nxt = fr_key;
                        deb_nxt  = 3'd1;
                        if (DEB_N == 3'd1) accept = 1'b1;
                        else               state_nxt = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (fr_kind == FR_SINGLE) begin
                        if (fr_key == cand) begin
                            if (deb + 3'd1 == DEB_N) accept = 1'b1;
                            else                     deb_nxt = deb + 3'd1;
                        end else begin
                            cand_nxt = fr_key;
                            deb_nxt  = 3'd1;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                HELD: begin
                    if (fr_kind == FR_NONE) begin
                        deb_nxt   = 3'd1;
                        state_nxt = (DEB_N == 3'd1) ? IDLE : RELEASE_DEB;
                    end
                end
                RELEASE_DEB: begin
                    if (fr_kind == FR_NONE) begin
                        if (deb + 3'd1 == DEB_N) state_nxt = IDLE;
                        else                     deb_nxt = deb + 3'd1;
                    end else begin
                        state_nxt = HELD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (accept) state_nxt = HELD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            deb         <= '0;
            cand        <= '0;
            key_code_r  <= '0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            press_cnt_r <= '0;
        end else begin
            state       <= state_nxt;
            deb         <= deb_nxt;
            cand        <= cand_nxt;
            key_valid_r <= accept;
            key_held_r  <= (state_nxt == HELD) || (state_nxt == RELEASE_DEB);
            if (accept) begin
                key_code_r  <= cand_nxt;
                press_cnt_r <= press_cnt_r + 8'd1;
            end
        end
    end

endmodule
